// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with shadow/active banks committed at frame end.
// Latency: outputs registered; write->shadow 1 cycle; commit visible at first drive slot of next frame.
// Backpressure: none; writes and commits are always accepted, repeated commits merge.
module seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(DIGITS)-1:0]  wr_idx,
    input  logic [6:0]                 wr_seg,
    input  logic                       commit,
    output logic [6:0]                 seg_out,
    output logic [DIGITS-1:0]          dig_en,
    output logic                       frame_tick,
    output logic                       pending
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(PRESCALE);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK);
    localparam logic [IDX_W-1:0] DIG_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    // run is low only between reset release and the first edge, so that
    // first edge lands on slot cycle 0 of digit 0 instead of advancing past it.
    logic             run;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             slot_last;
    logic             frame_end;
    logic             do_xfer;
    logic             wr_ok;
    logic             in_blank;

    logic [6:0]       shadow     [DIGITS];
    logic [6:0]       active     [DIGITS];
    logic [6:0]       active_nxt [DIGITS];

    phase_t           phase;
    phase_t           phase_nxt;

    logic [6:0]        seg_nxt;
    logic [DIGITS-1:0] dig_nxt;
    logic              tick_nxt;

    // Slot counter and digit index advance; frozen until the first edge after reset.
    always_comb begin
        slot_last = (cnt == PRE_LAST);
        frame_end = run && slot_last && (idx == DIG_LAST);
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        if (run) begin
            if (slot_last) begin
                cnt_nxt = '0;
                idx_nxt = (idx == DIG_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // Scan position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= '0;
            idx <= '0;
        end else begin
            run <= 1'b1;
            cnt <= cnt_nxt;
            idx <= idx_nxt;
        end
    end

    // A commit arriving in the frame-end cycle itself still transfers at that frame end.
    always_comb begin
        do_xfer = frame_end && (pending || commit);
        wr_ok   = wr_en && (int'(wr_idx) < DIGITS);
        for (int d = 0; d < DIGITS; d++) begin
            active_nxt[d] = do_xfer ? shadow[d] : active[d];
        end
    end

    // Shadow bank: host writes land here only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < DIGITS; d++) begin
                shadow[d] <= '0;
            end
        end else if (wr_ok) begin
            shadow[wr_idx] <= wr_seg;
        end
    end

    // Active bank: copied from the pre-write shadow at frame end, so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < DIGITS; d++) begin
                active[d] <= '0;
            end
        end else begin
            for (int d = 0; d < DIGITS; d++) begin
                active[d] <= active_nxt[d];
            end
        end
    end

    // Pending flag: set by commit, cleared when the transfer happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (do_xfer) begin
            pending <= 1'b0;
        end else if (commit) begin
            pending <= 1'b1;
        end
    end

    // Blank window test on the upcoming slot position; a zero-length window never blanks.
    generate
        if (BLANK == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (cnt_nxt < BLANK_C);
        end
    endgenerate

    // Phase FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_BLANK;
        end else begin
            phase <= phase_nxt;
        end
    end

    // Phase FSM next state: leave BLANK once past the window, re-enter at each new slot.
    always_comb begin
        phase_nxt = phase;
        case (phase)
            PH_BLANK: if (!in_blank) phase_nxt = PH_DRIVE;
            PH_DRIVE: if (in_blank)  phase_nxt = PH_BLANK;
            default:  phase_nxt = PH_BLANK;
        endcase
    end

    // Phase FSM outputs, computed for the upcoming cycle so the output flops line up with cnt/idx.
    // active_nxt is used so a transfer is visible immediately when there is no blank window.
    always_comb begin
        seg_nxt  = '0;
        dig_nxt  = '0;
        tick_nxt = (cnt_nxt == PRE_LAST) && (idx_nxt == DIG_LAST);
        if (phase_nxt == PH_DRIVE) begin
            seg_nxt = active_nxt[idx_nxt];
            dig_nxt = DIGITS'(1) << idx_nxt;
        end
    end

    // Output flops; reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= '0;
            dig_en     <= '0;
            frame_tick <= 1'b0;
        end else begin
            seg_out    <= seg_nxt;
            dig_en     <= dig_nxt;
            frame_tick <= tick_nxt;
        end
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed 7-segment display driver that sits directly downstream of the team's 5-bit-to-7-segment combinational decoder. It accepts segment patterns {a,b,c,d,e,f,g} per digit into a shadow bank and commits them to an active bank only at frame boundaries, so the display never tears. It then scans the active bank across DIGITS common-enable lines, with a programmable slot length and an anti-ghosting blank interval.

## Interface
- DIGITS, 4, number of multiplexed digits (2..8)
- PRESCALE, 1000, clock cycles per digit slot (≥2)
- BLANK, 16, leading cycles of each slot with all outputs off (0 ≤ BLANK < PRESCALE)
- clk  in  1  single system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write wr_seg into shadow[wr_idx] this cycle
- wr_idx  in  clog2(DIGITS)  shadow digit index; index ≥ DIGITS is ignored
- wr_seg  in  7  segment pattern, bit 6 = a … bit 0 = g, active-high
- commit  in  1  single-cycle request: copy shadow→active at next frame end
- seg_out  out  7  segment drive for current digit, bit 6 = a … bit 0 = g, active-high
- dig_en  out  DIGITS  one-hot digit enable, active-high; all-zero while blanking
- frame_tick  out  1  one-cycle pulse in final cycle of last digit's slot
- pending  out  1  commit requested, not yet applied

## Operation
- State: cnt (0..PRESCALE-1), idx (0..DIGITS-1), shadow[DIGITS][7], active[DIGITS][7], pending flag, phase FSM {BLANK, DRIVE}.
- Each cycle cnt increments. At cnt == PRESCALE-1, cnt wraps to 0 and idx advances; idx wraps DIGITS-1 → 0.
- FSM: BLANK while cnt < BLANK; DRIVE otherwise. BLANK=0 → DRIVE for the whole slot.
- BLANK: seg_out = 0, dig_en = 0.
- DRIVE: seg_out = active[idx], dig_en = 1 << idx.
- Frame end = cycle with cnt == PRESCALE-1 and idx == DIGITS-1. frame_tick = 1 in exactly that cycle.
- wr_en: shadow[wr_idx] ← wr_seg on that edge. Active bank is untouched. Out-of-range index: no effect.
- commit sets pending. At frame end with pending=1: active ← shadow (all digits), pending ← 0.
- commit in the frame-end cycle itself applies at that same frame end.
- wr_en in the frame-end cycle while a transfer occurs: active receives the pre-write shadow; the write lands in shadow only.
- Repeated commit while pending: no additional effect.
- Async reset: cnt, idx, pending, shadow, active all cleared to 0. FSM → BLANK. seg_out = 0, dig_en = 0, frame_tick = 0.
- Reset mid-slot: outputs go 0 immediately, without waiting for clk. Any pending commit is discarded.
- All outputs are driven from flops; no combinational path from inputs to outputs.

## Timing
- First rising edge after rst_n deasserts is slot cycle 0 of digit 0.
- Observable sequence per slot: BLANK cycles blank, then PRESCALE-BLANK cycles driving.
- Frame length: DIGITS × PRESCALE cycles.
- Commit latency: new patterns appear at the first DRIVE cycle of digit 0 in the frame following the frame end that applied them.
- Worst-case commit latency: DIGITS×PRESCALE + BLANK cycles.
- Write → shadow: 1 cycle. Shadow is not visible on outputs until a commit is applied.

## Test plan
Parameters for all scenarios: DIGITS=4, PRESCALE=8, BLANK=2.

- **Reset / idle scan.** Hold rst_n=0, then release.
  - During reset: all outputs 0.
  - After release: cycles 0-1 blank; cycles 2-7 dig_en=0001, seg_out=0000000; cycles 10-15 dig_en=0010.
  - frame_tick first high at cycle 31, then every 32 cycles, one cycle wide.
- **Write + commit.** Write shadow[0]=1111110 and shadow[1]=0110000, then pulse commit at cycle 5.
  - pending=1 and outputs stay 0 through cycle 31.
  - Cycles 34-39: dig_en=0001, seg_out=1111110.
  - Cycles 42-47: dig_en=0010, seg_out=0110000.
  - pending=0 from cycle 32.
- **Write without commit.** Write shadow[2]=1101101 and never commit.
  - Digit 2 stays 0000000 for at least 3 frames; pending stays 0.
- **Frame-end collision.** In cycle 31, pulse commit and write shadow[3]=1111001, with shadow[3] previously 0110011.
  - Next frame, digit 3 (cycles 58-63) shows 0110011.
  - Second commit: 1111001 appears one frame later.
- **Mid-operation reset.** Assert rst_n=0 at cycle 44 while digit 1 is driving committed data.
  - seg_out and dig_en go 0 asynchronously, and pending clears.
  - After release: 2 blank cycles, then digit 0 shows 0000000.
- **No blanking.** Rerun with BLANK=0.
  - dig_en is never all-zero after reset release.
  - dig_en steps 0001→0010 with no gap.
